// File: rtl/mem_responder.sv
// mem_responder
//   Single-outstanding memory model answering a cache controller. Each
//   request is accepted only in IDLE, waits exactly LAT cycles, then is
//   held as a response until the controller takes it.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous, active-low reset
//   req_valid  request presented          req_ready  accept possible (IDLE)
//   req_write  1 = write, 0 = read        req_addr   word address
//   req_wdata  write data (reads ignore it)
//   rsp_valid  response available         rsp_ready  controller takes response
//   rsp_write  echo of answered type      rsp_rdata  read data, 0 for writes
//   busy       FSM not in IDLE
//   rd_count / wr_count  completed responses, saturating at 16'hFFFF
module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    logic [1:0]        state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              wr_q,        wr_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0]       rd_count_q,  rd_count_d;
    logic [15:0]       wr_count_q,  wr_count_d;
    logic              mem_we;

    // Backing store: deliberately outside the reset domain.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d     = S_RESP;
                    rsp_write_d = wr_q;
                    rsp_rdata_d = wr_q ? '0 : mem[addr_q];
                    // Gate with reset so an abandoned write never commits.
                    mem_we      = wr_q & reset;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    if (rsp_write_q) begin
                        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
                    end else begin
                        if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder (LAT=3). Expected responses are pushed
//   on acceptance using a reference memory and popped when rsp_valid shows.
module tb_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [15:0] rd_count, wr_count;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(32), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] exp_q [$];
    logic [31:0] model_mem [logic [7:0]];
    logic [15:0] m_rd = 16'd0;
    logic [15:0] m_wr = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic w, input logic [7:0] a, input logic [31:0] d);
        if (w) begin
            model_mem[a] = d;
            exp_q.push_back({1'b1, 32'h0});
        end else begin
            exp_q.push_back({1'b0, model_mem[a]});
        end
    endtask

    task automatic pop_cmp;
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_write", {31'd0, rsp_write}, {31'd0, e[32]});
            chk("rsp_rdata", rsp_rdata, e[31:0]);
        end
    endtask

    // One full transaction with exact-latency check, optional stall in RESP
    // while req_* inputs are scrambled, then handshake and counter check.
    task automatic transact(input logic w, input logic [7:0] a, input logic [31:0] d,
                            input int stall);
        int n;
        logic [31:0] held;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        tick;
        req_valid = 1'b0;
        push_exp(w, a, d);
        chk("busy_wait", {31'd0, busy}, 32'd1);
        chk("req_ready_wait", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick;
            n++;
        end
        chk("latency", n, LAT);
        if (rsp_valid) begin
            held = rsp_rdata;
            for (int s = 0; s < stall; s++) begin
                req_valid = 1'b1; req_write = ~w; req_addr = a ^ 8'hFF; req_wdata = ~d;
                tick;
                chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                chk("stall_rdata", rsp_rdata, held);
                chk("stall_ready", {31'd0, req_ready}, 32'd0);
                chk("stall_rd", {16'd0, rd_count}, {16'd0, m_rd});
                chk("stall_wr", {16'd0, wr_count}, {16'd0, m_wr});
            end
            req_valid = 1'b0;
            pop_cmp();
            chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
            if (w) begin
                if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
            end else begin
                if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
            end
            chk("rd_count", {16'd0, rd_count}, {16'd0, m_rd});
            chk("wr_count", {16'd0, wr_count}, {16'd0, m_wr});
            chk("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
            chk("req_ready_done", {31'd0, req_ready}, 32'd1);
        end
    endtask

    logic [7:0]  b_addr [4];
    logic [31:0] b_data [4];
    logic        b_wr   [4];

    initial begin
        int n;
        int acc_prev;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        @(negedge clk);
        tick;
        tick;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_write", {31'd0, rsp_write}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_counts", {rd_count, wr_count}, 32'd0);
        reset = 1'b1;
        tick;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Write then read-back, the read stalled 5 cycles in RESP.
        transact(1'b1, 8'h10, 32'hDEADBEEF, 0);
        transact(1'b0, 8'h10, 32'h0, 5);

        // Reset one cycle into WAIT abandons the write to 8'h20.
        transact(1'b1, 8'h20, 32'hA5A5A5A5, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 32'h12345678;
        tick;
        req_valid = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        m_rd = 16'd0; m_wr = 16'd0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_counts", {rd_count, wr_count}, 32'd0);
        transact(1'b0, 8'h20, 32'h0, 0);

        // Back-to-back with rsp_ready tied high and req_valid held.
        b_wr[0] = 1'b1; b_addr[0] = 8'h30; b_data[0] = 32'hCAFE0001;
        b_wr[1] = 1'b0; b_addr[1] = 8'h30; b_data[1] = 32'h0;
        b_wr[2] = 1'b1; b_addr[2] = 8'h31; b_data[2] = 32'h0BADF00D;
        b_wr[3] = 1'b0; b_addr[3] = 8'h31; b_data[3] = 32'h0;
        rsp_ready = 1'b1;
        acc_prev = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_write = b_wr[i]; req_addr = b_addr[i]; req_wdata = b_data[i];
            n = 0;
            while (!req_ready && n < 20) begin
                tick;
                n++;
            end
            tick;
            if (i > 0) chk("b2b_interval", cyc - acc_prev, LAT + 2);
            acc_prev = cyc;
            push_exp(b_wr[i], b_addr[i], b_data[i]);
            if (i == 3) req_valid = 1'b0;
            n = 0;
            while (!rsp_valid && n < 20) begin
                tick;
                n++;
            end
            chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            if (rsp_valid) pop_cmp();
        end
        tick;
        rsp_ready = 1'b0;
        m_rd = m_rd + 16'd2; m_wr = m_wr + 16'd2;
        chk("b2b_rd", {16'd0, rd_count}, {16'd0, m_rd});
        chk("b2b_wr", {16'd0, wr_count}, {16'd0, m_wr});

        // Saturation: preload wr_count to FFFE, then two more writes.
        force dut.wr_count_q = 16'hFFFE;
        #1;
        release dut.wr_count_q;
        m_wr = 16'hFFFE;
        chk("preload_wr", {16'd0, wr_count}, 32'h0000FFFE);
        transact(1'b1, 8'h40, 32'h11111111, 0);
        transact(1'b1, 8'h41, 32'h22222222, 0);
        chk("sat_wr", {16'd0, wr_count}, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
